// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one-outstanding req/gnt/rvalid
// fetches and holds the returned instruction in a one-entry IF/ID buffer.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating perf counters.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_INC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        id_stall,
  input  logic        halt,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  output logic        inst_valid,
  output logic [15:0] inst_ifid,
  output logic [15:0] pc_ifid,
  output logic [15:0] pc_plus_ifid,
  output logic        err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt
`endif
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam logic [AW-1:0] INC = AW'(PC_INC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          squash_q, squash_d;
  logic          halting_q, halting_d;
  logic          req_pend_q, req_pend_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] inst_q, inst_d;
  logic [AW-1:0] pc_id_q, pc_id_d;
  logic [AW-1:0] pcp_q, pcp_d;
  logic          err_q, err_d;

  logic halt_now;
  logic consume;
  logic redir;

  assign halt_now = halting_q | halt;
  assign consume  = vld_q & ~id_stall;
  // Halt outranks redirect; redirects only matter while fetching.
  assign redir    = redirect_valid & ~halt_now;

  // Next-state, request generation and buffer control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    halting_d  = halting_q;
    req_pend_d = req_pend_q;
    req_addr_d = req_addr_q;
    vld_d      = vld_q;
    inst_d     = inst_q;
    pc_id_d    = pc_id_q;
    pcp_d      = pcp_q;
    err_d      = err_q;
    mem_req    = 1'b0;
    // An ungranted request keeps presenting its original address.
    mem_addr   = req_pend_q ? req_addr_q : pc_q;

    if (consume) vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (req_pend_q)
          mem_req = 1'b1;
        else if (!halt_now && (!vld_q || !id_stall))
          mem_req = 1'b1;

        if (halt) halting_d = 1'b1;
        if (mem_req) req_addr_d = mem_addr;
        if (mem_req && halt_now) squash_d = 1'b1;

        if (mem_req && mem_gnt) begin
          req_pend_d = 1'b0;
          state_d    = S_WAIT;
          // A stale (squashed) request must not advance the PC.
          if (!squash_q) pc_d = pc_q + INC;
        end else if (mem_req) begin
          req_pend_d = 1'b1;
        end else if (halt_now && !vld_q) begin
          state_d = S_HALT;
        end else if (halt_now && consume) begin
          state_d = S_HALT;
        end

        if (redir) begin
          pc_d  = redirect_pc;
          vld_d = 1'b0;
          if (mem_req) squash_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (halt) halting_d = 1'b1;
        if (halt_now || redir) squash_d = 1'b1;
        if (redir) begin
          pc_d  = redirect_pc;
          vld_d = 1'b0;
        end
        if (mem_rvalid) begin
          squash_d = 1'b0;
          state_d  = S_FETCH;
          if (!squash_q && !redir && !halt_now) begin
            if (mem_err) begin
              err_d   = 1'b1;
              vld_d   = 1'b0;
              state_d = S_HALT;
            end else begin
              vld_d   = 1'b1;
              inst_d  = mem_rdata;
              pc_id_d = req_addr_q;
              pcp_d   = req_addr_q + INC;
            end
          end
        end
      end

      S_HALT: begin
        vld_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      squash_q   <= 1'b0;
      halting_q  <= 1'b0;
      req_pend_q <= 1'b0;
      req_addr_q <= RESET_PC;
      vld_q      <= 1'b0;
      inst_q     <= '0;
      pc_id_q    <= RESET_PC;
      pcp_q      <= RESET_PC + INC;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      squash_q   <= squash_d;
      halting_q  <= halting_d;
      req_pend_q <= req_pend_d;
      req_addr_q <= req_addr_d;
      vld_q      <= vld_d;
      inst_q     <= inst_d;
      pc_id_q    <= pc_id_d;
      pcp_q      <= pcp_d;
      err_q      <= err_d;
    end
  end

  assign inst_valid   = vld_q;
  assign inst_ifid    = inst_q;
  assign pc_ifid      = pc_id_q;
  assign pc_plus_ifid = pcp_q;
  assign err          = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counts of consumed instructions and back-pressured cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (consume && (fetch_cnt_q != 16'hFFFF))
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (vld_q && id_stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a memory model answers grants, expected
// grant addresses and delivered instructions are queued by the stimulus and
// popped by independent monitors.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_stall;
  logic        halt;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata  = 16'h0000;
  logic        mem_err    = 1'b0;
  logic        inst_valid;
  logic [15:0] inst_ifid;
  logic [15:0] pc_ifid;
  logic [15:0] pc_plus_ifid;
  logic        err;

  logic        gnt_en   = 1'b1;
  int          lat      = 1;
  logic [15:0] err_addr = 16'hDEAD;

  int checks = 0;
  int errors = 0;
  int gcount = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_pc_q[$];

  logic        g_seen = 1'b0;
  logic [15:0] g_addr = 16'h0000;
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] mon_pc;

  always #5 clk = ~clk;

  assign mem_gnt = mem_req & gnt_en;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .halt           (halt),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .inst_valid     (inst_valid),
    .inst_ifid      (inst_ifid),
    .pc_ifid        (pc_ifid),
    .pc_plus_ifid   (pc_plus_ifid),
    .err            (err)
  );

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant monitor: every accepted request must match the next queued address.
  always @(negedge clk) begin
    g_seen = mem_req && mem_gnt;
    g_addr = mem_addr;
    if (g_seen) begin
      gcount++;
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_addr: unexpected request to %h at %0t", mem_addr, $time);
      end else begin
        check("grant_addr", mem_addr, exp_addr_q.pop_front());
      end
    end
  end

  // Memory model: response lat cycles after the grant, regardless of reset.
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    if (g_seen) begin
      m_busy = 1'b1;
      m_cnt  = lat;
      m_addr = g_addr;
    end
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_data(m_addr);
        mem_err    = (m_addr == err_addr);
        m_busy     = 1'b0;
      end
    end
  end

  // Delivery monitor: each consumed instruction must match the next queued PC.
  always @(negedge clk) begin
    if (rst && inst_valid && !id_stall) begin
      if (exp_pc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver: unexpected inst %h pc %h at %0t", inst_ifid, pc_ifid, $time);
      end else begin
        mon_pc = exp_pc_q.pop_front();
        check("deliver_pc", pc_ifid, mon_pc);
        check("deliver_inst", inst_ifid, mem_data(mon_pc));
        check("deliver_pc_plus", pc_plus_ifid, mon_pc + 16'd2);
      end
    end
  end

  task automatic wait_gnt(input int n);
    int i;
    i = 0;
    while (gcount < n && i < 300) begin
      @(negedge clk);
      #1;
      i++;
    end
    checks++;
    if (gcount < n) begin
      errors++;
      $display("FAIL wait_gnt: got %0d grants expected %0d", gcount, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    id_stall       = 1'b0;
    halt           = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 16'(mem_req), 16'd0);
    check("rst_inst_valid", 16'(inst_valid), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("rst_inst", inst_ifid, 16'h0000);
    check("rst_pc", pc_ifid, 16'h0000);
    check("rst_pc_plus", pc_plus_ifid, 16'h0002);

    // Sequential fetch from RESET_PC, one instruction every two cycles
    exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0004); exp_addr_q.push_back(16'h0006);
    exp_pc_q.push_back(16'h0000); exp_pc_q.push_back(16'h0002);
    exp_pc_q.push_back(16'h0004); exp_pc_q.push_back(16'h0006);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_gnt(4);

    // Decode back-pressure holds the buffer and blocks new requests
    id_stall = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 16'(inst_valid), 16'd1);
      check("stall_inst", inst_ifid, mem_data(16'h0006));
      check("stall_mem_req", 16'(mem_req), 16'd0);
    end
    @(posedge clk); #1;
    exp_addr_q.push_back(16'h0008);
    id_stall = 1'b0;
    lat      = 3;
    @(negedge clk);
    check("release_mem_req", 16'(mem_req), 16'd1);
    check("release_mem_addr", mem_addr, 16'h0008);

    // Redirect while waiting: the 0x0008 response is dropped
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    lat            = 1;
    exp_addr_q.push_back(16'h0100); exp_addr_q.push_back(16'h0102);
    exp_addr_q.push_back(16'h0104);
    exp_pc_q.push_back(16'h0100); exp_pc_q.push_back(16'h0102);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_gnt(7);

    // Redirect with an ungranted request: old address held, then squashed
    gnt_en = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFC;
    @(negedge clk);
    check("ungnt_req", 16'(mem_req), 16'd1);
    check("ungnt_addr", mem_addr, 16'h0104);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("ungnt_req_hold", 16'(mem_req), 16'd1);
    check("ungnt_addr_hold", mem_addr, 16'h0104);
    check("ungnt_flushed", 16'(inst_valid), 16'd0);

    // Wrap past 0xFFFE, then an error response on 0x0002
    exp_addr_q.push_back(16'hFFFC); exp_addr_q.push_back(16'hFFFE);
    exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0002);
    exp_pc_q.push_back(16'hFFFC); exp_pc_q.push_back(16'hFFFE);
    exp_pc_q.push_back(16'h0000);
    err_addr = 16'h0002;
    @(posedge clk); #1;
    gnt_en = 1'b1;
    wait_gnt(12);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check("err_sticky", 16'(err), 16'd1);
      check("err_mem_req", 16'(mem_req), 16'd0);
      check("err_inst_valid", 16'(inst_valid), 16'd0);
    end

    // Reset clears the error; stale response across reset is ignored
    @(posedge clk); #1;
    rst      = 1'b0;
    err_addr = 16'hDEAD;
    lat      = 2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst2_err", 16'(err), 16'd0);
    check("rst2_mem_req", 16'(mem_req), 16'd0);
    check("rst2_inst_valid", 16'(inst_valid), 16'd0);
    check("rst2_pc", pc_ifid, 16'h0000);
    exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0002);
    exp_pc_q.push_back(16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_gnt(13);
    rst = 1'b0;
    lat = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("stale_ignored", 16'(inst_valid), 16'd0);
    wait_gnt(14);
    lat = 3;
    wait_gnt(15);

    // Halt with a response in flight: squashed, no further requests
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      check("halt_mem_req", 16'(mem_req), 16'd0);
      check("halt_inst_valid", 16'(inst_valid), 16'd0);
    end
    check("halt_err", 16'(err), 16'd0);
    check("addr_queue_empty", 16'(exp_addr_q.size()), 16'd0);
    check("inst_queue_empty", 16'(exp_pc_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
